// File: rtl/game_pkg.sv
// Shared types and constants for the guessing-game front end.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } debounce_state_t;

    localparam int DEBOUNCE_DEFAULT = 50000;
    localparam int PRESS_CNT_W      = 8;
    localparam int DEBOUNCE_CNT_W   = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Shift the raw value through two flops so metastability settles before use.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/guess_input_conditioner.sv
// Conditions the enter button and guess switches: synchronise, debounce,
// emit one enter pulse per press with the guess latched on that cycle.
module guess_input_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int GUESS_W         = 8,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_btn_raw,
    input  logic [GUESS_W-1:0]     i_guess_raw,
    output logic                   o_enter,
    output logic [GUESS_W-1:0]     o_guess,
    output logic [PRESS_CNT_W-1:0] o_press_count,
    output logic                   o_btn_level
);

    // Terminal value of the stability counter; a level must hold this many cycles.
    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    // The button synchroniser resets to whatever the board reads when released.
    localparam logic BTN_RELEASED = (BTN_ACTIVE_LOW != 0);

    logic                      w_btn_sync;
    logic                      w_btn_s;
    logic [GUESS_W-1:0]        w_guess_sync;

    debounce_state_t           r_state;
    debounce_state_t           w_state_nxt;
    logic [DEBOUNCE_CNT_W-1:0] r_cnt;
    logic [DEBOUNCE_CNT_W-1:0] w_cnt_nxt;
    logic                      w_accept;

    logic                      r_enter;
    logic [GUESS_W-1:0]        r_guess;
    logic [PRESS_CNT_W-1:0]    r_press_count;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (BTN_RELEASED)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_btn_raw),
        .o_q   (w_btn_sync)
    );

    sync_2ff #(
        .WIDTH     (GUESS_W),
        .RESET_VAL ('0)
    ) u_guess_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_guess_raw),
        .o_q   (w_guess_sync)
    );

    assign w_btn_s = (BTN_ACTIVE_LOW != 0) ? ~w_btn_sync : w_btn_sync;

    // Debounce decision: a level change is accepted only after it has held steadily.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HELD;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + DEBOUNCE_CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + DEBOUNCE_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Debounce state and stability counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Accepted press: pulse enter for one cycle, capture the guess, bump the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enter       <= 1'b0;
            r_guess       <= '0;
            r_press_count <= '0;
        end else begin
            r_enter <= w_accept;
            if (w_accept) begin
                r_guess       <= w_guess_sync;
                r_press_count <= r_press_count + PRESS_CNT_W'(1);
            end
        end
    end

    assign o_enter       = r_enter;
    assign o_guess       = r_guess;
    assign o_press_count = r_press_count;
    assign o_btn_level   = (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);

endmodule

// File: tb/tb_guess_input_conditioner.sv
// Bench for guess_input_conditioner with a short debounce window.
module tb_guess_input_conditioner;

    localparam int DEB = 4;
    localparam int GW  = 8;
    localparam int PULSE_LAT = DEB + 3;

    logic          clk         = 1'b0;
    logic          reset       = 1'b0;
    logic          i_btn_raw   = 1'b1;
    logic [GW-1:0] i_guess_raw = '0;
    logic          o_enter;
    logic [GW-1:0] o_guess;
    logic [7:0]    o_press_count;
    logic          o_btn_level;

    typedef struct {
        int         edgeNum;
        logic [7:0] guess;
        logic [7:0] count;
    } pulse_t;

    pulse_t     sb[$];
    logic [7:0] expCount  = '0;
    logic       prevEnter = 1'b0;
    int         edgeCnt   = 0;
    int         checks    = 0;
    int         errors    = 0;

    guess_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .GUESS_W         (GW),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_btn_raw     (i_btn_raw),
        .i_guess_raw   (i_guess_raw),
        .o_enter       (o_enter),
        .o_guess       (o_guess),
        .o_press_count (o_press_count),
        .o_btn_level   (o_btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right as the raw button is driven pressed and then held.
    task automatic expectPulse(input logic [7:0] g);
        pulse_t e;
        expCount++;
        e.edgeNum = edgeCnt + PULSE_LAT;
        e.guess   = g;
        e.count   = expCount;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] g, input int holdCycles);
        @(negedge clk);
        i_guess_raw = g;
        waitCycles(3);
        i_btn_raw = 1'b0;
        expectPulse(g);
        waitCycles(holdCycles);
        checkOutput("btn_level_held", o_btn_level, 1'b1);
        i_btn_raw = 1'b1;
        waitCycles(12);
        checkOutput("btn_level_released", o_btn_level, 1'b0);
    endtask

    // Match every enter pulse against the next expected press.
    always @(negedge clk) begin
        pulse_t e;
        if (o_enter) begin
            checkOutput("enter_back_to_back", prevEnter, 1'b0);
            checkOutput("pulse_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("pulse_edge", edgeCnt, e.edgeNum);
                checkOutput("pulse_guess", o_guess, e.guess);
                checkOutput("pulse_count", o_press_count, e.count);
            end
        end else if (sb.size() != 0 && edgeCnt > sb[0].edgeNum) begin
            checkOutput("pulse_missing_edge", edgeCnt, sb[0].edgeNum);
            void'(sb.pop_front());
        end
        prevEnter = o_enter;
    end

    initial begin
        // Reset values
        #1;
        checkOutput("rst_enter", o_enter, 1'b0);
        checkOutput("rst_guess", o_guess, 8'h00);
        checkOutput("rst_count", o_press_count, 8'h00);
        checkOutput("rst_level", o_btn_level, 1'b0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(2);

        // Clean press held for 20 cycles
        applyStimulus(8'h5A, 20);
        checkOutput("guess_holds", o_guess, 8'h5A);

        // Press bounce 1,0,1,0 with single-cycle glitches, then stable press
        @(negedge clk);
        i_guess_raw = 8'h77;
        waitCycles(3);
        i_btn_raw = 1'b0; waitCycles(1);
        i_btn_raw = 1'b1; waitCycles(1);
        i_btn_raw = 1'b0; waitCycles(1);
        i_btn_raw = 1'b1; waitCycles(1);
        i_btn_raw = 1'b0;
        expectPulse(8'h77);
        waitCycles(15);
        checkOutput("bounce_level_held", o_btn_level, 1'b1);
        i_btn_raw = 1'b1;
        waitCycles(12);

        // Release bounce and switch change while held
        @(negedge clk);
        i_guess_raw = 8'h10;
        waitCycles(3);
        i_btn_raw = 1'b0;
        expectPulse(8'h10);
        waitCycles(10);
        checkOutput("held_guess", o_guess, 8'h10);
        i_guess_raw = 8'h20;
        waitCycles(5);
        checkOutput("held_guess_after_switch", o_guess, 8'h10);
        i_btn_raw = 1'b1;
        for (int i = 0; i < 2; i++) begin
            waitCycles(1);
            checkOutput("glitch_level_a", o_btn_level, 1'b1);
        end
        i_btn_raw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            waitCycles(1);
            checkOutput("glitch_level_b", o_btn_level, 1'b1);
        end
        i_btn_raw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitCycles(1);
            checkOutput("glitch_level_c", o_btn_level, 1'b1);
        end
        waitCycles(10);
        checkOutput("release_level", o_btn_level, 1'b0);
        checkOutput("guess_before_next", o_guess, 8'h10);
        applyStimulus(8'h20, 12);
        checkOutput("guess_next_press", o_guess, 8'h20);

        // Press count wrap
        while (expCount != 8'hFF) applyStimulus(expCount ^ 8'hA5, 10);
        applyStimulus(8'hC3, 10);
        checkOutput("count_wrap_0", o_press_count, 8'h00);
        applyStimulus(8'h3C, 10);
        checkOutput("count_wrap_1", o_press_count, 8'h01);

        // Reset mid-count, button held through reset release
        @(negedge clk);
        i_guess_raw = 8'h3C;
        waitCycles(3);
        i_btn_raw = 1'b0;
        waitCycles(5);
        reset = 1'b0;
        expCount = '0;
        #1;
        checkOutput("midrst_enter", o_enter, 1'b0);
        checkOutput("midrst_guess", o_guess, 8'h00);
        checkOutput("midrst_count", o_press_count, 8'h00);
        checkOutput("midrst_level", o_btn_level, 1'b0);
        waitCycles(3);
        reset = 1'b1;
        expectPulse(8'h3C);
        waitCycles(15);
        checkOutput("post_rst_level", o_btn_level, 1'b1);
        i_btn_raw = 1'b1;
        waitCycles(12);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
